// File: rtl/uart_echo_if.sv
// Receive/transmit handshake bundle for the UART echo controller.
// slave is the controller's view; master is the receiver/transmitter side.
interface uart_echo_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;

  modport master (
    output in_data, in_valid, tx_busy,
    input  tx_start, tx_data
  );

  modport slave (
    input  in_data, in_valid, tx_busy,
    output tx_start, tx_data
  );
endinterface

// File: rtl/uart_echo_ctrl.sv
// Circular buffer between UART receiver and transmitter with four echo modes,
// saturating overrun counter and a launch/guard/drain handshake with tx_busy.
module uart_echo_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_echo_if.slave             bus,
  input  logic [1:0]             mode,
  input  logic                   drop_clr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [DROP_W-1:0]      drop_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DATA_W-1:0] LF = DATA_W'(8'h0A);
  localparam logic [DATA_W-1:0] CR = DATA_W'(8'h0D);

  typedef enum logic [1:0] {IDLE, LAUNCH, GUARD, DRAIN} state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg, term_cnt_reg;
  logic [DROP_W-1:0]   drop_reg;
  logic                pending_lf_reg;
  logic [DATA_W-1:0]   tx_data_reg;

  logic [DATA_W-1:0]   head, head_xf;
  logic                wr_en, drop, pop, lf_launch, eligible;
  logic                term_inc, term_dec;

  function automatic logic is_term(input logic [DATA_W-1:0] w);
    return (w == LF) || (w == CR);
  endfunction

  assign head     = mem[rd_ptr_reg];
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign wr_en    = bus.in_valid && !full;
  assign drop     = bus.in_valid && full;
  // Line mode holds data back until a terminator is buffered; a full buffer forces progress.
  assign eligible = !empty && ((mode != 2'b11) || (term_cnt_reg != '0) || full);
  assign term_inc = wr_en && is_term(bus.in_data);
  assign term_dec = pop && is_term(head);

  generate
    if (DATA_W == 8) begin : g_upper
      always_comb begin
        head_xf = head;
        if (mode == 2'b01 && head >= 8'h61 && head <= 8'h7A)
          head_xf = head - 8'h20;
      end
    end else begin : g_ident
      assign head_xf = head;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    lf_launch  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!bus.tx_busy) begin
          if (pending_lf_reg) begin
            lf_launch  = 1'b1;
            state_next = LAUNCH;
          end else if (eligible) begin
            pop        = 1'b1;
            state_next = LAUNCH;
          end
        end
      end
      LAUNCH:  state_next = GUARD;
      GUARD:   state_next = DRAIN;
      DRAIN:   if (!bus.tx_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      term_cnt_reg   <= '0;
      drop_reg       <= '0;
      pending_lf_reg <= 1'b0;
      tx_data_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);

      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase

      case ({term_inc, term_dec})
        2'b10:   term_cnt_reg <= term_cnt_reg + CNT_W'(1);
        2'b01:   term_cnt_reg <= term_cnt_reg - CNT_W'(1);
        default: term_cnt_reg <= term_cnt_reg;
      endcase

      if (drop_clr)
        drop_reg <= '0;
      else if (drop && drop_reg != {DROP_W{1'b1}})
        drop_reg <= drop_reg + DROP_W'(1);

      if (lf_launch) begin
        tx_data_reg    <= LF;
        pending_lf_reg <= 1'b0;
      end else if (pop) begin
        tx_data_reg <= head_xf;
        if (mode == 2'b10 && head_xf == CR) pending_lf_reg <= 1'b1;
      end
    end
  end

  assign bus.tx_start = (state_reg == LAUNCH);
  assign bus.tx_data  = tx_data_reg;
  assign count        = count_reg;
  assign drop_count   = drop_reg;
endmodule
